// File: rtl/dot_pkg.sv
// dot_pkg: shared encodings, geometry and helpers for the dot-matrix scan controller
package dot_pkg;
    localparam int ROWS = 8;
    localparam int COLS = 16;
    localparam logic [7:0] ROW_IDLE = 8'hFF;
    localparam logic [7:0][7:0] ROW_SEL = {8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_SET = 2'b01, OP_CLR = 2'b10, OP_TOG = 2'b11} op_e;
    typedef enum logic {CL_RUN, CL_CLEAR} clr_state_e;
    typedef enum logic {SC_ON, SC_GAP} scan_state_e;
    function automatic logic [COLS-1:0] apply_op(input logic [COLS-1:0] row, input logic [3:0] col, input op_e op);
        logic [COLS-1:0] m;
        m = '0;
        m[col] = 1'b1;
        return op == OP_SET ? row | m : op == OP_CLR ? row & ~m : op == OP_TOG ? row ^ m : row;
    endfunction
endpackage

// File: rtl/dot_scan_ctrl_if.sv
// dot_scan_ctrl_if: the two cell-write request channels (keypad = 0, game logic = 1)
interface dot_scan_ctrl_if;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_row;
    logic [3:0] req0_col;
    logic [1:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_row;
    logic [3:0] req1_col;
    logic [1:0] req1_op;
    modport master (
        output req0_valid, req0_row, req0_col, req0_op,
        output req1_valid, req1_row, req1_col, req1_op,
        input  req0_ready, req1_ready
    );
    modport slave (
        input  req0_valid, req0_row, req0_col, req0_op,
        input  req1_valid, req1_row, req1_col, req1_op,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/dot_rr_arbiter.sv
// dot_rr_arbiter: two-requester round-robin, one grant per cycle
module dot_rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic ptr;
    // Contested cycles go to the pointer side; a lone requester wins outright
    always_comb begin
        grant = 2'b00;
        if (en) grant = &valid ? (ptr ? 2'b10 : 2'b01) : valid;
    end
    // Pointer moves past whoever was just granted
    always_ff @(posedge clock) begin
        if (reset) ptr <= 1'b0;
        else if (|grant) ptr <= grant[0];
    end
endmodule

// File: rtl/dot_scan_ctrl.sv
// dot_scan_ctrl: arbitrated 8x16 frame buffer with bulk clear and blanked row scanning
module dot_scan_ctrl
    import dot_pkg::*;
#(
    parameter int SCAN_DIV  = 2500,
    parameter int BLANK_CYC = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    dot_scan_ctrl_if.slave        bus,
    input  logic                  clr_all,
    input  logic                  blank,
    input  logic [2:0]            rd_row,
    output logic [COLS-1:0]       rd_data,
    output logic                  frame_start,
    output logic                  clear_busy,
    output logic [7:0]            dotR,
    output logic [COLS-1:0]       dotC
);
    localparam int CNT_W = $clog2(SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC) + 1;

    logic [COLS-1:0] buf_q [ROWS];
    clr_state_e      clr_q, clr_d;
    logic [2:0]      clr_cnt;
    scan_state_e     scan_q, scan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      row_q, row_d;
    logic [COLS-1:0] dotc_q;
    logic            latch;
    logic [1:0]      grant;
    logic [2:0]      wr_row;
    logic [3:0]      wr_col;
    op_e             wr_op;

    dot_rr_arbiter u_arb (
        .clock (clock),
        .reset (reset),
        .en    (!reset && clr_q == CL_RUN && !clr_all),
        .valid ({bus.req1_valid, bus.req0_valid}),
        .grant (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign wr_row = grant[1] ? bus.req1_row : bus.req0_row;
    assign wr_col = grant[1] ? bus.req1_col : bus.req0_col;
    assign wr_op  = op_e'(grant[1] ? bus.req1_op : bus.req0_op);
    assign clear_busy = clr_q == CL_CLEAR;

    // Bulk clear: one row per cycle, further clr_all pulses ignored until done
    always_comb begin
        clr_d = clr_q;
        if (clr_q == CL_RUN && clr_all) clr_d = CL_CLEAR;
        else if (clr_q == CL_CLEAR && clr_cnt == 3'd7) clr_d = CL_RUN;
    end

    // Clear state and row counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_q   <= CL_RUN;
            clr_cnt <= 3'd0;
        end else begin
            clr_q   <= clr_d;
            clr_cnt <= clear_busy ? clr_cnt + 3'd1 : 3'd0;
        end
    end

    // Frame buffer: clear has priority, otherwise apply the granted op
    always_ff @(posedge clock) begin
        if (reset) for (int i = 0; i < ROWS; i++) buf_q[i] <= '0;
        else if (clear_busy) buf_q[clr_cnt] <= '0;
        else if (|grant) buf_q[wr_row] <= apply_op(buf_q[wr_row], wr_col, wr_op);
    end

    // Registered read-back port
    always_ff @(posedge clock) begin
        rd_data <= reset ? '0 : buf_q[rd_row];
    end

    // Scan sequencing: ON for SCAN_DIV cycles, GAP for BLANK_CYC, row advances entering ON
    always_comb begin
        scan_d = scan_q;
        cnt_d  = cnt_q + 1'b1;
        row_d  = row_q;
        latch  = 1'b0;
        if (scan_q == SC_GAP && cnt_q == CNT_W'(BLANK_CYC - 1)) begin
            scan_d = SC_ON;
            cnt_d  = '0;
            row_d  = row_q + 3'd1;
            latch  = 1'b1;
        end else if (scan_q == SC_ON && cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_d = SC_GAP;
            cnt_d  = '0;
        end
    end

    // Scan registers; column data is captured only at row start so it never changes mid-ON
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_q      <= SC_GAP;
            cnt_q       <= '0;
            row_q       <= 3'd7;
            dotc_q      <= '0;
            frame_start <= 1'b0;
        end else begin
            scan_q      <= scan_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            frame_start <= latch && row_d == 3'd0;
            if (latch) dotc_q <= buf_q[row_d];
        end
    end

    assign dotR = (scan_q == SC_ON && !blank) ? ROW_SEL[row_q] : ROW_IDLE;
    assign dotC = (scan_q == SC_ON && !blank) ? dotc_q : '0;
endmodule

// File: tb/tb_dot_scan_ctrl.sv
// tb_dot_scan_ctrl: directed scoreboard bench for dot_scan_ctrl (SCAN_DIV=4, BLANK_CYC=1)
module tb_dot_scan_ctrl;
    logic clock = 1'b0, reset = 1'b1, clr_all = 1'b0, blank = 1'b0, mon_en = 1'b0;
    logic [2:0] rd_row = 3'd0;
    logic [15:0] rd_data, dotC;
    logic [7:0] dotR;
    logic frame_start, clear_busy;
    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [15:0] mdl [8];
    logic [15:0] disp = 16'h0;
    logic [15:0] exp_rd [$];
    logic [1:0] exp_g [$];
    logic on_m;
    logic [7:0] er;
    int r_m;

    dot_scan_ctrl_if bus();

    dot_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clock(clock), .reset(reset), .bus(bus), .clr_all(clr_all), .blank(blank),
        .rd_row(rd_row), .rd_data(rd_data), .frame_start(frame_start),
        .clear_busy(clear_busy), .dotR(dotR), .dotC(dotC)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_op(input logic [2:0] r, input logic [3:0] c, input logic [1:0] op);
        logic [15:0] m;
        m = 16'h1 << c;
        if (op == 2'b01) mdl[r] = mdl[r] | m;
        else if (op == 2'b10) mdl[r] = mdl[r] & ~m;
        else if (op == 2'b11) mdl[r] = mdl[r] ^ m;
    endtask

    task automatic wr(input int p, input logic [2:0] r, input logic [3:0] c, input logic [1:0] op);
        @(posedge clock); #2;
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_row = r; bus.req0_col = c; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_row = r; bus.req1_col = c; bus.req1_op = op;
        end
        #1 chk(p == 0 ? "req0_ready" : "req1_ready", p == 0 ? bus.req0_ready : bus.req1_ready, 1);
        @(posedge clock); #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        model_op(r, c, op);
    endtask

    task automatic read_check(input logic [2:0] r);
        @(posedge clock); #2;
        rd_row = r;
        exp_rd.push_back(mdl[r]);
        @(posedge clock); #1;
        chk($sformatf("rd_data[%0d]", r), rd_data, exp_rd.pop_front());
    endtask

    // Scan monitor: expected row drive, column data and frame pulse from the cycle count since reset
    always @(negedge clock) begin
        if (mon_en) begin
            on_m = cyc % 5 != 0;
            r_m  = ((cyc - 1) / 5) % 8;
            er   = ~(8'h80 >> r_m);
            chk("dotR", dotR, (on_m && !blank) ? er : 8'hFF);
            chk("dotC", dotC, (on_m && !blank) ? disp : 16'h0);
            chk("frame_start", frame_start, cyc % 40 == 1);
            if (!on_m) disp = mdl[(cyc / 5) % 8];
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
        bus.req0_valid = 1'b0; bus.req0_row = 3'd0; bus.req0_col = 4'd0; bus.req0_op = 2'b00;
        bus.req1_valid = 1'b0; bus.req1_row = 3'd0; bus.req1_col = 4'd0; bus.req1_op = 2'b00;

        @(posedge clock); #2;
        bus.req0_valid = 1'b1;
        bus.req0_op = 2'b01;
        #1;
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_dotR", dotR, 8'hFF);
        chk("rst_dotC", dotC, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_clear_busy", clear_busy, 0);
        @(posedge clock); #2;
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (45) @(posedge clock);

        exp_g.push_back(2'b01); exp_g.push_back(2'b10);
        exp_g.push_back(2'b01); exp_g.push_back(2'b10);
        @(posedge clock); #2;
        bus.req0_valid = 1'b1; bus.req0_row = 3'd0; bus.req0_col = 4'd0; bus.req0_op = 2'b01;
        bus.req1_valid = 1'b1; bus.req1_row = 3'd0; bus.req1_col = 4'd1; bus.req1_op = 2'b01;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
            #1;
            g = exp_g.pop_front();
            chk("grant_order", {bus.req1_ready, bus.req0_ready}, g);
            @(posedge clock); #2;
            model_op(3'd0, g[1] ? 4'd1 : 4'd0, 2'b01);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        read_check(3'd0);

        wr(0, 3'd2, 4'd5, 2'b01);
        read_check(3'd2);
        repeat (40) @(posedge clock);

        wr(1, 3'd7, 4'd15, 2'b11);
        read_check(3'd7);
        wr(1, 3'd7, 4'd15, 2'b11);
        read_check(3'd7);
        wr(0, 3'd2, 4'd5, 2'b00);
        read_check(3'd2);
        wr(1, 3'd2, 4'd5, 2'b10);
        read_check(3'd2);

        for (int r = 0; r < 8; r++) wr(0, 3'(r), 4'(2 * r + 1), 2'b01);
        read_check(3'd5);

        @(posedge clock); #2;
        clr_all = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_row = 3'd3; bus.req1_col = 4'd3; bus.req1_op = 2'b01;
        #1;
        chk("clr_pulse_req1_ready", bus.req1_ready, 0);
        chk("clr_pulse_busy", clear_busy, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #2;
            if (k > 0) mdl[k - 1] = 16'h0;
            clr_all = (k == 3);
            #1;
            chk("clear_busy", clear_busy, 1);
            chk("clr_req1_ready", bus.req1_ready, 0);
        end
        @(posedge clock); #2;
        mdl[7] = 16'h0;
        clr_all = 1'b0;
        #1;
        chk("clear_done", clear_busy, 0);
        chk("first_run_req1_ready", bus.req1_ready, 1);
        @(posedge clock); #2;
        bus.req1_valid = 1'b0;
        model_op(3'd3, 4'd3, 2'b01);
        for (int r = 0; r < 8; r++) read_check(3'(r));

        repeat (7) @(posedge clock);
        #2 blank = 1'b1;
        #1;
        chk("blank_dotR", dotR, 8'hFF);
        chk("blank_dotC", dotC, 0);
        repeat (13) @(posedge clock);
        #2 blank = 1'b0;
        repeat (30) @(posedge clock);

        @(posedge clock); #2 clr_all = 1'b1;
        @(posedge clock); #2 clr_all = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
        mon_en = 1'b0;
        @(posedge clock); #2;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
        reset = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("midclr_reset_busy", clear_busy, 0);
        chk("midclr_reset_dotR", dotR, 8'hFF);
        read_check(3'd3);
        read_check(3'd7);
        repeat (12) @(posedge clock);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dot_scan_ctrl.md
# dot_scan_ctrl

Owns the 8×16 dot-matrix frame buffer and shares it between two write requesters (keypad cell marking and game logic), while continuously scanning it onto the active-low row / active-high column drivers. It replaces ad-hoc `pos` writes and free-running row scans with one arbitrated, glitch-free controller. It sits between the game FSM / keypad decoder and the board pins `dotR`/`dotC`.

## Interface
- `SCAN_DIV`, 2500: clock cycles each row is driven ON.
- `BLANK_CYC`, 2: all-off cycles between rows (anti-ghosting); must be ≥1.
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `req0_valid` / `req1_valid`  in  1  write request (0 = keypad, 1 = game logic)
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid&&ready
- `req0_row` / `req1_row`  in  3  target row 0..7
- `req0_col` / `req1_col`  in  4  target column 0..15
- `req0_op` / `req1_op`  in  2  00 NOP, 01 SET, 10 CLR, 11 TOGGLE
- `clr_all`  in  1  one-cycle pulse: clear whole buffer
- `blank`  in  1  level: force display off, scanning continues
- `rd_row`  in  3  read-back row select
- `rd_data`  out  16  buffer row `rd_row`, registered
- `frame_start`  out  1  one-cycle pulse when row 0 is latched
- `clear_busy`  out  1  high while bulk clear in progress
- `dotR`  out  8  row drive, active low; row r drives bit (7−r) low
- `dotC`  out  16  column drive, active high; bit c = column c

## Operation
- Buffer: 8 rows × 16 bits; cell (r,c) = row r bit c.
- Arbiter: 2-way round-robin, one grant per cycle. Pointer starts at requester 0 after reset and moves past the granted requester on each grant. A lone valid requester is granted immediately. `ready` is combinational from valid, pointer and state; the loser's ready is 0.
- Ops apply on the grant cycle. NOP is accepted but changes nothing. TOGGLE inverts the cell.
- Bulk clear FSM states: RUN, CLEAR. On `clr_all` in RUN → CLEAR, zeroing row k on the k-th cycle (8 cycles). `clear_busy`=1 and both readys=0 throughout, then → RUN. A `clr_all` arriving during CLEAR is ignored.
- Scan FSM states: ON, GAP. ON lasts SCAN_DIV cycles; GAP lasts BLANK_CYC cycles.
  - At GAP→ON the row index advances (7 wraps to 0) and the row's buffer contents are latched into the `dotC` register.
  - In GAP: `dotR`=8'hFF and `dotC`=0.
  - `blank`=1 forces `dotR`=8'hFF and `dotC`=0 while the scan counters keep running.
- `rd_data` <= buffer[`rd_row`] every cycle; it reflects writes one cycle after they commit.

## Timing
- Reset values:
  - `dotR`=8'hFF, `dotC`=0, buffer all 0.
  - `rd_data`=0, `frame_start`=0, `clear_busy`=0, readys 0 during reset.
  - Scan enters GAP with row index 7, so the first latched row is row 0, BLANK_CYC cycles after reset release.
- Write latency: the buffer is updated on the edge ending the grant cycle.
- Display latency: a write appears on `dotC` at that row's next latch. The displayed row is never changed mid-ON.
- Row period = SCAN_DIV+BLANK_CYC; frame period = 8× the row period. `frame_start` coincides with the first ON cycle of row 0.
- Simultaneous `clr_all` and a valid request: clear wins, the request is not granted, and the requester must hold valid.
- Both requesters on the same cell: executed in grant order over consecutive cycles.
- Reset mid-CLEAR or mid-scan: returns to the reset state on the next edge; any partial clear is discarded since the buffer goes to 0.

## Structure
- Package `dot_pkg`: op encoding (NOP/SET/CLR/TOGGLE), ROWS=8, COLS=16, row-select one-hot-low table, idle pattern 8'hFF.
- Sub-module `dot_rr_arbiter`: 2-requester round-robin with grant and pointer update. The remaining logic (buffer, clear FSM, scan FSM) stays in `dot_scan_ctrl`.

## Test plan
- Reset, then hold idle with SCAN_DIV=4, BLANK_CYC=1 → `dotR` cycles 7F,BF,…,FE with an FF gap of 1 cycle between each; `dotC`=0; `frame_start` every 40 cycles.
- req0 SET (2,5) → `req0_ready`=1 same cycle; `rd_row`=2 gives `rd_data`=16'h0020 two cycles later; `dotC`=16'h0020 while `dotR`=8'hDF.
- req0 and req1 both valid for 4 cycles with SET (0,0) and SET (0,1) → grants alternate 0,1,0,1; row 0 = 16'h0003.
- TOGGLE (7,15) twice → row 7 goes 16'h8000 then 16'h0000.
- Fill buffer, pulse `clr_all` with req1 valid → `clear_busy` high for 8 cycles with `req1_ready`=0; all rows then read 0; req1 is granted on the first RUN cycle.
- Assert `blank` mid-frame → `dotR`=FF and `dotC`=0 immediately; on deassert the scan resumes at the correct row with the phase unchanged.
